// File: rtl/aes_pkg.sv
// Shared definitions for the AES round controller: FSM state encoding,
// round counts per key size and the default round-index width.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int AES128_NR   = 10;
    localparam int AES192_NR   = 12;
    localparam int AES256_NR   = 14;
    localparam int AES_ROUND_W = 4;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block request / result handshake between a requester and aes_round_ctrl.
interface aes_round_ctrl_if;

    logic start_valid;
    logic start_ready;
    logic abort;
    logic done_valid;
    logic done_ready;

    modport master (
        output start_valid,
        output abort,
        output done_ready,
        input  start_ready,
        input  done_valid
    );

    modport slave (
        input  start_valid,
        input  abort,
        input  done_ready,
        output start_ready,
        output done_valid
    );

endinterface

// File: rtl/aes_round_cnt.sv
// Round index counter: clears to 0, counts up by one, holds at NR.
module aes_round_cnt
    import aes_pkg::*;
#(
    parameter int NR      = AES128_NR,
    parameter int ROUND_W = AES_ROUND_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [ROUND_W-1:0] cnt
);

    localparam logic [ROUND_W-1:0] CNT_MAX = ROUND_W'(NR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + ROUND_W'(1);
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: LOAD, NR-1 middle rounds, FINAL, then holds the
// result in DONE until it is taken; abort drops the block and clears the state.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR      = AES128_NR,
    parameter int ROUND_W = AES_ROUND_W
) (
    input  logic               clk,
    input  logic               rst,
    aes_round_ctrl_if.slave    hs,
    output logic               reg_en,
    output logic               reg_clr,
    output logic               sel_init,
    output logic               last_round,
    output logic               key_en,
    output logic [ROUND_W-1:0] round,
    output logic               busy
);

    localparam logic [ROUND_W-1:0] ROUND_PENULT = ROUND_W'(NR - 1);

    state_t state;
    state_t state_nxt;
    logic   rdy_q;
    logic   clr_q;
    logic   aborting;
    logic   start_ok;
    logic   cnt_clr;
    logic   cnt_inc;

    // rdy_q keeps start_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            rdy_q <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= 1'b1;
            clr_q <= aborting;
        end
    end

    assign aborting = hs.abort && (state != ST_IDLE);
    assign start_ok = rdy_q && ((state == ST_IDLE) ||
                                ((state == ST_DONE) && hs.done_ready));

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        if (aborting) begin
            state_nxt = ST_IDLE;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hs.start_valid && start_ok) state_nxt = ST_LOAD;
                end
                ST_LOAD: begin
                    state_nxt = ST_ROUND;
                    cnt_inc   = 1'b1;
                end
                ST_ROUND: begin
                    cnt_inc = 1'b1;
                    if (round == ROUND_PENULT) state_nxt = ST_FINAL;
                end
                ST_FINAL: begin
                    state_nxt = ST_DONE;
                end
                ST_DONE: begin
                    if (hs.done_ready) begin
                        cnt_clr   = 1'b1;
                        state_nxt = hs.start_valid ? ST_LOAD : ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_clr   = 1'b1;
                end
            endcase
        end
    end

    aes_round_cnt #(
        .NR      (NR),
        .ROUND_W (ROUND_W)
    ) u_round_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cnt (round)
    );

    assign hs.start_ready = start_ok;
    assign hs.done_valid  = (state == ST_DONE);
    assign reg_en         = (state == ST_LOAD) || (state == ST_ROUND) || (state == ST_FINAL);
    assign sel_init       = (state == ST_LOAD);
    assign key_en         = (state == ST_ROUND) || (state == ST_FINAL);
    assign last_round     = (state == ST_FINAL);
    assign busy           = (state != ST_IDLE);
    assign reg_clr        = clr_q;

endmodule
